// File: rtl/pdr_pkg.sv
// ============================================================================
// Module   : pdr_pkg
// Brief    : Shared constants, field indices and FSM state type for the PDR
//            match unit and its rule table.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pdr_pkg;

    localparam int NUM_FIELDS = 9;
    localparam int NUM_WE     = 11;

    localparam int FLD_IN_PORT          = 0;
    localparam int FLD_SA_UNDERLAY      = 1;
    localparam int FLD_DA_UNDERLAY      = 2;
    localparam int FLD_GTPU_TEID        = 3;
    localparam int FLD_GTPU_QFI         = 4;
    localparam int FLD_SA_OVERLAY       = 5;
    localparam int FLD_DA_OVERLAY       = 6;
    localparam int FLD_SP_DP_OVERLAY    = 7;
    localparam int FLD_PROTOCOL_OVERLAY = 8;

    localparam int WE_CFG    = 9;
    localparam int WE_ACTION = 10;

    localparam int CFG_VALID_BIT = 31;
    localparam int ACTION_WIDTH  = 26;
    localparam int CTRL_WIDTH    = 30;
    localparam int VCODE_MSB     = 29;
    localparam int VCODE_LSB     = 26;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_OUTPUT = 2'd2
    } pdr_state_e;

endpackage : pdr_pkg

`default_nettype wire

// File: rtl/pdr_rule_table.sv
// ============================================================================
// Module   : pdr_rule_table
// Brief    : PDR rule storage with per-field write enables and a combinational
//            read port; reads return pre-write contents within a cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pdr_rule_table
    import pdr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [ADDR_WIDTH-1:0]                    W_ADDR,
    input  logic [NUM_WE-1:0]                        Write_Enables,
    input  logic [DATA_WIDTH-1:0]                    Write_Data,
    input  logic [ADDR_WIDTH-1:0]                    rd_idx,
    output logic                                     rd_valid,
    output logic [NUM_FIELDS-1:0]                    rd_mask,
    output logic [NUM_FIELDS-1:0][DATA_WIDTH-1:0]    rd_keys,
    output logic [ACTION_WIDTH-1:0]                  rd_action
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [c_DEPTH-1:0]                                 r_valid;
    logic [c_DEPTH-1:0][NUM_FIELDS-1:0]                 r_mask;
    logic [c_DEPTH-1:0][NUM_FIELDS-1:0][DATA_WIDTH-1:0] r_keys;
    logic [c_DEPTH-1:0][ACTION_WIDTH-1:0]               r_action;

    generate
        for (genvar e = 0; e < c_DEPTH; e++) begin : g_entry
            logic w_sel;
            assign w_sel = (W_ADDR == ADDR_WIDTH'(e));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid[e]  <= 1'b0;
                    r_mask[e]   <= '0;
                    r_action[e] <= '0;
                end else begin
                    if (w_sel && Write_Enables[WE_CFG]) begin
                        r_valid[e] <= Write_Data[CFG_VALID_BIT];
                        r_mask[e]  <= Write_Data[NUM_FIELDS-1:0];
                    end
                    if (w_sel && Write_Enables[WE_ACTION]) begin
                        r_action[e] <= Write_Data[ACTION_WIDTH-1:0];
                    end
                end
            end

            for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_keys[e][f] <= '0;
                    end else if (w_sel && Write_Enables[f]) begin
                        r_keys[e][f] <= Write_Data;
                    end
                end
            end
        end
    endgenerate

    assign rd_valid  = r_valid[rd_idx];
    assign rd_mask   = r_mask[rd_idx];
    assign rd_keys   = r_keys[rd_idx];
    assign rd_action = r_action[rd_idx];

endmodule : pdr_rule_table

`default_nettype wire

// File: rtl/pdr_match_unit.sv
// ============================================================================
// Module   : pdr_match_unit
// Brief    : Sequential PDR classifier: scans the rule table one entry per
//            cycle, lowest index wins, result held until handshaken.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pdr_match_unit
    import pdr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    input  logic [3:0]              In_Vcode,
    input  logic [DATA_WIDTH-1:0]   In_In_Port,
    input  logic [DATA_WIDTH-1:0]   In_SA_underlay_IPv4,
    input  logic [DATA_WIDTH-1:0]   In_DA_underlay_IPv4,
    input  logic [DATA_WIDTH-1:0]   In_GTPU_TEID,
    input  logic [DATA_WIDTH-1:0]   In_GTPU_QFI,
    input  logic [DATA_WIDTH-1:0]   In_SA_overlay_IPv4,
    input  logic [DATA_WIDTH-1:0]   In_DA_overlay_IPv4,
    input  logic [DATA_WIDTH-1:0]   In_SP_DP_overlay,
    input  logic [DATA_WIDTH-1:0]   In_Protocol_overlay,
    input  logic [ADDR_WIDTH-1:0]   W_ADDR,
    input  logic [NUM_WE-1:0]       Write_Enables,
    input  logic [DATA_WIDTH-1:0]   Write_Data,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic                    Out_Hit,
    output logic [ADDR_WIDTH-1:0]   PDR_ID,
    output logic [CTRL_WIDTH-1:0]   Out_Control,
    output logic [DATA_WIDTH-1:0]   Out_In_Port,
    output logic [DATA_WIDTH-1:0]   Out_SA_underlay_IPv4,
    output logic [DATA_WIDTH-1:0]   Out_DA_underlay_IPv4,
    output logic [DATA_WIDTH-1:0]   Out_GTPU_TEID,
    output logic [DATA_WIDTH-1:0]   Out_GTPU_QFI,
    output logic [DATA_WIDTH-1:0]   Out_SA_overlay_IPv4,
    output logic [DATA_WIDTH-1:0]   Out_DA_overlay_IPv4,
    output logic [DATA_WIDTH-1:0]   Out_SP_DP_overlay,
    output logic [DATA_WIDTH-1:0]   Out_Protocol_overlay
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    pdr_state_e                              r_state;
    pdr_state_e                              w_state_next;
    logic [ADDR_WIDTH-1:0]                   r_idx;
    logic [3:0]                              r_vcode;
    logic [NUM_FIELDS-1:0][DATA_WIDTH-1:0]   r_hdr;
    logic [NUM_FIELDS-1:0][DATA_WIDTH-1:0]   w_hdr;
    logic                                    r_hit;
    logic [ADDR_WIDTH-1:0]                   r_pdr_id;
    logic [CTRL_WIDTH-1:0]                   r_control;
    logic                                    r_out_valid;

    logic                                    w_accept;
    logic                                    w_decide;
    logic                                    w_idx_inc;
    logic                                    w_release;

    logic                                    w_rd_valid;
    logic [NUM_FIELDS-1:0]                   w_rd_mask;
    logic [NUM_FIELDS-1:0][DATA_WIDTH-1:0]   w_rd_keys;
    logic [ACTION_WIDTH-1:0]                 w_rd_action;
    logic [NUM_FIELDS-1:0]                   w_field_ok;
    logic                                    w_match;
    logic                                    w_last;

    assign w_hdr[FLD_IN_PORT]          = In_In_Port;
    assign w_hdr[FLD_SA_UNDERLAY]      = In_SA_underlay_IPv4;
    assign w_hdr[FLD_DA_UNDERLAY]      = In_DA_underlay_IPv4;
    assign w_hdr[FLD_GTPU_TEID]        = In_GTPU_TEID;
    assign w_hdr[FLD_GTPU_QFI]         = In_GTPU_QFI;
    assign w_hdr[FLD_SA_OVERLAY]       = In_SA_overlay_IPv4;
    assign w_hdr[FLD_DA_OVERLAY]       = In_DA_overlay_IPv4;
    assign w_hdr[FLD_SP_DP_OVERLAY]    = In_SP_DP_overlay;
    assign w_hdr[FLD_PROTOCOL_OVERLAY] = In_Protocol_overlay;

    pdr_rule_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_table (
        .clk           (clk),
        .rst           (rst),
        .W_ADDR        (W_ADDR),
        .Write_Enables (Write_Enables),
        .Write_Data    (Write_Data),
        .rd_idx        (r_idx),
        .rd_valid      (w_rd_valid),
        .rd_mask       (w_rd_mask),
        .rd_keys       (w_rd_keys),
        .rd_action     (w_rd_action)
    );

    // Masked-out fields always pass, so a valid entry with mask 0 is a wildcard.
    generate
        for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_cmp
            assign w_field_ok[f] = !w_rd_mask[f] || (r_hdr[f] == w_rd_keys[f]);
        end
    endgenerate

    assign w_match = w_rd_valid && (&w_field_ok);
    assign w_last  = (r_idx == ADDR_WIDTH'(c_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_decide     = 1'b0;
        w_idx_inc    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (In_Valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (w_match || w_last) begin
                    w_decide     = 1'b1;
                    w_state_next = ST_OUTPUT;
                end else begin
                    w_idx_inc = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (r_out_valid && Out_Ready) begin
                    w_release    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Result registers load on the decision edge; Out_Valid follows one cycle
    // later so the presented result comes entirely from settled registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_vcode     <= '0;
            r_hdr       <= '0;
            r_hit       <= 1'b0;
            r_pdr_id    <= '0;
            r_control   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hdr   <= w_hdr;
                r_vcode <= In_Vcode;
                r_idx   <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + ADDR_WIDTH'(1);
            end
            if (w_decide) begin
                r_hit     <= w_match;
                r_pdr_id  <= w_match ? r_idx : '0;
                r_control <= {r_vcode, (w_match ? w_rd_action : ACTION_WIDTH'(0))};
            end
            if (w_release) begin
                r_out_valid <= 1'b0;
            end else if (r_state == ST_OUTPUT) begin
                r_out_valid <= 1'b1;
            end
        end
    end

    assign In_Ready    = (r_state == ST_IDLE);
    assign Out_Valid   = r_out_valid;
    assign Out_Hit     = r_hit;
    assign PDR_ID      = r_pdr_id;
    assign Out_Control = r_control;

    assign Out_In_Port          = r_hdr[FLD_IN_PORT];
    assign Out_SA_underlay_IPv4 = r_hdr[FLD_SA_UNDERLAY];
    assign Out_DA_underlay_IPv4 = r_hdr[FLD_DA_UNDERLAY];
    assign Out_GTPU_TEID        = r_hdr[FLD_GTPU_TEID];
    assign Out_GTPU_QFI         = r_hdr[FLD_GTPU_QFI];
    assign Out_SA_overlay_IPv4  = r_hdr[FLD_SA_OVERLAY];
    assign Out_DA_overlay_IPv4  = r_hdr[FLD_DA_OVERLAY];
    assign Out_SP_DP_overlay    = r_hdr[FLD_SP_DP_OVERLAY];
    assign Out_Protocol_overlay = r_hdr[FLD_PROTOCOL_OVERLAY];

endmodule : pdr_match_unit

`default_nettype wire

// File: tb/tb_pdr_match_unit.sv
// ============================================================================
// Module   : tb_pdr_match_unit
// Brief    : Directed self-checking bench for pdr_match_unit with a result
//            scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pdr_match_unit;

    logic               clk = 1'b0;
    logic               rst;
    logic               In_Valid;
    logic               In_Ready;
    logic [3:0]         In_Vcode;
    logic [8:0][31:0]   in_f;
    logic [8:0][31:0]   out_f;
    logic [1:0]         W_ADDR;
    logic [10:0]        Write_Enables;
    logic [31:0]        Write_Data;
    logic               Out_Valid;
    logic               Out_Ready;
    logic               Out_Hit;
    logic [1:0]         PDR_ID;
    logic [29:0]        Out_Control;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic             hit;
        logic [1:0]       id;
        logic [29:0]      ctrl;
        logic [8:0][31:0] f;
        int               lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pdr_match_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .In_Valid             (In_Valid),
        .In_Ready             (In_Ready),
        .In_Vcode             (In_Vcode),
        .In_In_Port           (in_f[0]),
        .In_SA_underlay_IPv4  (in_f[1]),
        .In_DA_underlay_IPv4  (in_f[2]),
        .In_GTPU_TEID         (in_f[3]),
        .In_GTPU_QFI          (in_f[4]),
        .In_SA_overlay_IPv4   (in_f[5]),
        .In_DA_overlay_IPv4   (in_f[6]),
        .In_SP_DP_overlay     (in_f[7]),
        .In_Protocol_overlay  (in_f[8]),
        .W_ADDR               (W_ADDR),
        .Write_Enables        (Write_Enables),
        .Write_Data           (Write_Data),
        .Out_Valid            (Out_Valid),
        .Out_Ready            (Out_Ready),
        .Out_Hit              (Out_Hit),
        .PDR_ID               (PDR_ID),
        .Out_Control          (Out_Control),
        .Out_In_Port          (out_f[0]),
        .Out_SA_underlay_IPv4 (out_f[1]),
        .Out_DA_underlay_IPv4 (out_f[2]),
        .Out_GTPU_TEID        (out_f[3]),
        .Out_GTPU_QFI         (out_f[4]),
        .Out_SA_overlay_IPv4  (out_f[5]),
        .Out_DA_overlay_IPv4  (out_f[6]),
        .Out_SP_DP_overlay    (out_f[7]),
        .Out_Protocol_overlay (out_f[8])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [10:0] we, input logic [31:0] d);
        @(negedge clk);
        W_ADDR        = a;
        Write_Enables = we;
        Write_Data    = d;
        @(negedge clk);
        Write_Enables = '0;
    endtask

    // Push expectation, drive one header, wait for the result and score it.
    task automatic send(input logic [3:0] vc, input logic [8:0][31:0] hdr,
                        input logic hit, input logic [1:0] id, input logic [25:0] act);
        exp_t e;
        exp_t got;
        int   cyc;
        e.hit  = hit;
        e.id   = hit ? id : 2'd0;
        e.ctrl = {vc, (hit ? act : 26'd0)};
        e.f    = hdr;
        e.lat  = hit ? (int'(id) + 2) : 5;
        sb.push_back(e);

        @(negedge clk);
        In_Valid = 1'b1;
        In_Vcode = vc;
        in_f     = hdr;
        check("in_ready_idle", {63'd0, In_Ready}, 64'd1);
        @(posedge clk);
        #1;
        In_Valid = 1'b0;
        In_Vcode = ~vc;
        in_f     = ~hdr;
        cyc = 0;
        while (!Out_Valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        got = sb.pop_front();
        check("latency", 64'(cyc), 64'(got.lat));
        check("out_valid", {63'd0, Out_Valid}, 64'd1);
        check("out_hit", {63'd0, Out_Hit}, {63'd0, got.hit});
        check("pdr_id", {62'd0, PDR_ID}, {62'd0, got.id});
        check("out_control", {34'd0, Out_Control}, {34'd0, got.ctrl});
        for (int i = 0; i < 9; i++) begin
            check($sformatf("field%0d", i), {32'd0, out_f[i]}, {32'd0, got.f[i]});
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        Out_Ready = 1'b1;
        @(posedge clk);
        #1;
        Out_Ready = 1'b0;
        check("valid_after_hs", {63'd0, Out_Valid}, 64'd0);
        check("ready_after_hs", {63'd0, In_Ready}, 64'd1);
    endtask

    initial begin
        logic [8:0][31:0] h;
        logic             seen_valid;

        rst           = 1'b1;
        In_Valid      = 1'b0;
        In_Vcode      = '0;
        in_f          = '0;
        W_ADDR        = '0;
        Write_Enables = '0;
        Write_Data    = '0;
        Out_Ready     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", {63'd0, Out_Valid}, 64'd0);
        check("rst_in_ready", {63'd0, In_Ready}, 64'd1);
        check("rst_out_hit", {63'd0, Out_Hit}, 64'd0);
        check("rst_pdr_id", {62'd0, PDR_ID}, 64'd0);
        check("rst_control", {34'd0, Out_Control}, 64'd0);
        check("rst_field8", {32'd0, out_f[8]}, 64'd0);

        // Empty table: miss after a full scan.
        for (int i = 0; i < 9; i++) h[i] = 32'h1000_0000 + 32'(i);
        h[0] = 32'd5;
        send(4'hA, h, 1'b0, 2'd0, 26'd0);
        release_result();

        // Entry 2 keyed on In_Port=7.
        wr(2'd2, 11'h001, 32'd7);
        wr(2'd2, 11'h400, 32'h0000_0155);
        wr(2'd2, 11'h200, 32'h8000_0001);
        h[0] = 32'd7;
        send(4'h3, h, 1'b1, 2'd2, 26'h0000155);
        release_result();
        h[0] = 32'd8;
        send(4'h3, h, 1'b0, 2'd0, 26'd0);
        release_result();

        // Entry 1 wildcard takes precedence over entry 2.
        wr(2'd1, 11'h400, 32'h0000_0001);
        wr(2'd1, 11'h200, 32'h8000_0000);
        h[0] = 32'd7;
        send(4'h5, h, 1'b1, 2'd1, 26'h1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {63'd0, Out_Valid}, 64'd1);
            check("hold_in_ready", {63'd0, In_Ready}, 64'd0);
            check("hold_pdr_id", {62'd0, PDR_ID}, 64'd1);
            check("hold_control", {34'd0, Out_Control}, {34'd0, 4'h5, 26'h1});
        end
        release_result();

        // Entry 0 with two-field mask; entry 1 disabled.
        wr(2'd1, 11'h200, 32'h0000_0000);
        wr(2'd0, 11'h004, 32'h0A00_0001);
        wr(2'd0, 11'h100, 32'd17);
        wr(2'd0, 11'h400, 32'h02AA_AAAA);
        wr(2'd0, 11'h200, 32'h8000_0104);
        h[0] = 32'd0;
        h[2] = 32'h0A00_0001;
        h[8] = 32'd6;
        send(4'h7, h, 1'b0, 2'd0, 26'd0);
        release_result();
        h[8] = 32'd17;
        send(4'h7, h, 1'b1, 2'd0, 26'h2AAAAAA);
        release_result();

        // Key and config written in one cycle from the same payload; last-entry hit.
        wr(2'd3, 11'h208, 32'h8000_0008);
        h[3] = 32'h8000_0008;
        h[8] = 32'd6;
        send(4'h9, h, 1'b1, 2'd3, 26'd0);
        release_result();

        // Reset mid-search drops the packet and clears the table.
        wr(2'd0, 11'h200, 32'h8000_0000);
        @(negedge clk);
        In_Valid = 1'b1;
        In_Vcode = 4'hC;
        in_f     = h;
        @(posedge clk);
        #1;
        In_Valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (Out_Valid) seen_valid = 1'b1;
        end
        check("rst_search_no_output", {63'd0, seen_valid}, 64'd0);
        check("rst_search_in_ready", {63'd0, In_Ready}, 64'd1);
        send(4'hC, h, 1'b0, 2'd0, 26'd0);
        release_result();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pdr_match_unit

`default_nettype wire

// File: doc/pdr_match_unit.md
Name: pdr_match_unit

Overview:
- Upstream neighbour of the action stage: classifies each parsed packet header against a small PDR rule table.
- Emits the winning PDR_ID, a hit flag and the 30-bit control word (Vcode + 26-bit action bitmap) with all nine header fields, ready for the action stage to consume.
- Sequential search: one table entry per cycle, lowest index wins, valid/ready handshakes on both sides.

Parameters:
DATA_WIDTH, 32, width of every header field and of Write_Data
ADDR_WIDTH, 2, PDR index width; table depth N = 2**ADDR_WIDTH

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
In_Valid  in  1  header word valid
In_Ready  out  1  unit can accept a header
In_Vcode  in  4  Vcode of the packet, passed to Out_Control[29:26]
In_In_Port, In_SA_underlay_IPv4, In_DA_underlay_IPv4, In_GTPU_TEID, In_GTPU_QFI, In_SA_overlay_IPv4, In_DA_overlay_IPv4, In_SP_DP_overlay, In_Protocol_overlay  in  DATA_WIDTH each  header fields 0..8
W_ADDR  in  ADDR_WIDTH  table entry to write
Write_Enables  in  11  [8:0] field key writes; [9] match config; [10] action bitmap
Write_Data  in  DATA_WIDTH  write payload
Out_Valid  out  1  result valid
Out_Ready  in  1  downstream accepts result
Out_Hit  out  1  1 = an entry matched
PDR_ID  out  ADDR_WIDTH  matching entry index (0 on miss)
Out_Control  out  30  {Vcode, action bitmap[25:0]}
Out_<field> x9 (same names as inputs, Out_ prefix)  out  DATA_WIDTH each  registered header copy

Behaviour:
- Table, per entry: valid bit, 9-bit match mask, nine DATA_WIDTH key values, 26-bit action bitmap.
- Writes at clk edge, independent of FSM state:
  - Write_Enables[f] (f = 0..8): key[W_ADDR][f] <= Write_Data.
  - Write_Enables[9]: valid <= Write_Data[31], mask <= Write_Data[8:0].
  - Write_Enables[10]: action <= Write_Data[25:0].
  - Multiple enables in one cycle all apply.
  - A compare in a given cycle sees table contents as they were before that cycle's write (read-before-write).
- Entry i matches iff valid[i] and, for every f with mask[i][f]=1, header field f == key[i][f]. A valid entry with mask 0 is a wildcard and matches everything.
- FSM states IDLE, SEARCH, OUTPUT:
  - IDLE: In_Ready=1. When In_Valid is high, latch Vcode and all 9 fields, set idx=0, go to SEARCH.
  - SEARCH: compare entry idx.
    - On match: PDR_ID=idx, Out_Hit=1, Out_Control={Vcode, action[idx]}, go to OUTPUT.
    - Else if idx==N-1: miss, PDR_ID=0, Out_Hit=0, Out_Control={Vcode, 26'b0}, go to OUTPUT.
    - Else idx++.
  - OUTPUT: Out_Valid=1. All outputs are held stable until Out_Ready is high, then go to IDLE.
- In_Ready is high only in IDLE. There is no same-cycle bypass, so a new header is accepted at the earliest one cycle after the output handshake.
- Latency: Out_Valid rises k+1 cycles after the accept edge, where k = hit index + 1, or N on a miss. Hit on entry 0 gives 2 cycles.
- idx is ADDR_WIDTH bits. It never wraps, because the search terminates at N-1.
- Reset (also mid-SEARCH/OUTPUT): state=IDLE, in-flight packet dropped, all entry valid/mask/action/keys cleared to 0. Outputs reset: Out_Valid=0, Out_Hit=0, PDR_ID=0, Out_Control=0, all Out_<field>=0, In_Ready=1 from the first cycle after reset.
- Writes are ignored in any cycle where rst=1.

Decomposition:
- Shared package pdr_pkg holds:
  - NUM_FIELDS=9.
  - Field index constants FLD_IN_PORT..FLD_PROTOCOL_OVERLAY (0..8).
  - Write-enable bit constants WE_CFG=9, WE_ACTION=10.
  - Control-word slice constants VCODE_MSB=29, VCODE_LSB=26.
  - FSM state enum.
- One sub-module, pdr_rule_table: storage plus write decode, with a combinational read port for entry idx returning valid/mask/keys/action. The compare logic and FSM stay in pdr_match_unit.

Test Plan:
- Reset, no writes; send header In_Port=5, Vcode=4'hA -> Out_Valid after 5 cycles (N=4 miss), Out_Hit=0, PDR_ID=0, Out_Control={4'hA, 26'b0}, fields echoed.
- Entry 2: valid, mask=9'b000000001, key In_Port=7, action=26'h0000155; send In_Port=7 -> Out_Hit=1, PDR_ID=2, Out_Control[25:0]=26'h0000155, Out_Valid 4 cycles after accept.
- Entry 1 wildcard (mask 0, action 26'h1) plus entry 2 as above; send In_Port=7 -> PDR_ID=1 (lowest index wins), latency 3.
- Hold Out_Ready=0 for 6 cycles with result pending -> outputs stable, In_Ready=0; raise Out_Ready -> In_Ready=1 the next cycle.
- Mask 9'b100000100 on entry 0 (DA_underlay=32'h0A000001, Protocol=17); send DA match with Protocol=6 -> miss on entry 0; send Protocol=17 -> hit PDR_ID=0, latency 2.
- Assert rst for 1 cycle during SEARCH -> Out_Valid stays 0, the packet is never emitted, and a previously configured entry no longer matches.
